// File: rtl/md_ctrl_pkg.sv
// Shared types and constants for the multdiv issue/completion controller.
// The state encoding is fixed so that the controller state can be decoded directly from its value.
package md_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  localparam logic [4:0]  RSTATUS_REG_DEF    = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE_DEF  = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE_DEF   = 32'd5;
  localparam int          TIMEOUT_CYCLES_DEF = 40;
  localparam int          CNT_W              = 6;

  function automatic logic [31:0] exc_code(input logic        is_div,
                                           input logic [31:0] mult_code,
                                           input logic [31:0] div_code);
    return is_div ? div_code : mult_code;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating watchdog counter for the BUSY phase.
// o_terminal flags the last cycle the unit is given before a forced exception.
module md_timeout_counter
  import md_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == TERM);

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/completion controller between the execute stage and the iterative multdiv unit.
// Launches one operation at a time, stalls until the unit answers (or times out), then emits one write-back beat.
module multdiv_ctrl
  import md_ctrl_pkg::*;
#(
  parameter logic [4:0]  RSTATUS_REG    = RSTATUS_REG_DEF,
  parameter logic [31:0] MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
  parameter logic [31:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_op_valid,
  input  logic        i_op_is_div,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [4:0]  i_op_rd,
  input  logic        i_flush,
  input  logic [31:0] i_md_result,
  input  logic        i_md_exception,
  input  logic        i_md_ready,
  output logic        o_md_ctrl_mult,
  output logic        o_md_ctrl_div,
  output logic [31:0] o_md_operand_a,
  output logic [31:0] o_md_operand_b,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_timeout
);

  md_state_t   r_state;
  md_state_t   w_state_next;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_kind;
  logic        r_exc;
  logic        r_timeout;

  logic w_terminal;
  logic w_accept;
  logic w_capture;
  logic w_live;
  logic w_wb_valid;
  logic w_to_rstatus;

  // Flush and reset silence every same-cycle side effect toward the pipeline.
  assign w_live = ~i_reset & ~i_flush;

  md_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (r_state == START),
    .i_enable  (r_state == BUSY),
    .o_terminal(w_terminal)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    if (i_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_op_valid) begin
            w_accept     = 1'b1;
            w_state_next = START;
          end
        end
        // Any md_ready seen here belongs to the previous operation.
        START: w_state_next = BUSY;
        BUSY: begin
          if (i_md_ready || w_terminal) begin
            w_capture    = 1'b1;
            w_state_next = DONE;
          end
        end
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_md_ctrl_mult = w_live & (r_state == START) & ~r_kind;
    o_md_ctrl_div  = w_live & (r_state == START) & r_kind;
    o_md_operand_a = i_reset ? '0 : r_op_a;
    o_md_operand_b = i_reset ? '0 : r_op_b;
    o_stall        = w_live & (((r_state == IDLE) & i_op_valid) |
                               (r_state == START) | (r_state == BUSY));
    o_busy         = ~i_reset & (r_state != IDLE);
    w_to_rstatus   = r_exc | r_timeout;
    // A clean result aimed at $r0 produces no beat at all.
    w_wb_valid     = w_live & (r_state == DONE) & (w_to_rstatus | (r_rd != '0));
    o_wb_valid     = w_wb_valid;
    o_wb_rd        = '0;
    o_wb_data      = '0;
    o_timeout      = 1'b0;
    if (w_wb_valid) begin
      o_wb_rd   = w_to_rstatus ? RSTATUS_REG : r_rd;
      o_wb_data = w_to_rstatus ? exc_code(r_kind, MULT_EXC_CODE, DIV_EXC_CODE) : r_result;
      o_timeout = r_timeout;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_kind    <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a <= i_op_a;
        r_op_b <= i_op_b;
        r_rd   <= i_op_rd;
        r_kind <= i_op_is_div;
      end
      if (w_capture) begin
        if (i_md_ready) begin
          r_result  <= i_md_result;
          r_exc     <= i_md_exception;
          r_timeout <= 1'b0;
        end else begin
          r_result  <= '0;
          r_exc     <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver plays both X stage and multdiv unit and
// queues expected pulses/write-backs; a negedge monitor compares everything the DUT presents.
module tb_multdiv_ctrl;

  localparam int          TO       = 40;
  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] MULT_EXC = 32'd4;
  localparam logic [31:0] DIV_EXC  = 32'd5;
  localparam int          NEVER    = 200;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_is_div, flush, md_exception, md_ready;
  logic [31:0] op_a, op_b, md_result;
  logic [4:0]  op_rd;
  logic        md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, timeout;
  logic [31:0] md_operand_a, md_operand_b, wb_data;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  multdiv_ctrl dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_op_valid    (op_valid),
    .i_op_is_div   (op_is_div),
    .i_op_a        (op_a),
    .i_op_b        (op_b),
    .i_op_rd       (op_rd),
    .i_flush       (flush),
    .i_md_result   (md_result),
    .i_md_exception(md_exception),
    .i_md_ready    (md_ready),
    .o_md_ctrl_mult(md_ctrl_mult),
    .o_md_ctrl_div (md_ctrl_div),
    .o_md_operand_a(md_operand_a),
    .o_md_operand_b(md_operand_b),
    .o_stall       (stall),
    .o_busy        (busy),
    .o_wb_valid    (wb_valid),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data),
    .o_timeout     (timeout)
  );

  typedef struct {
    int          cyc;
    bit          kind;
    logic [31:0] a;
    logic [31:0] b;
  } pulse_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          to;
  } wb_t;

  pulse_t pq[$];
  wb_t    wq[$];
  bit     exp_stall[int];
  bit     exp_busy[int];
  bit     dc_busy[int];
  bit     exp_quiet[int];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multdiv unit: signed 32-bit product/quotient, exception on overflow or /0.
  task automatic unit_model(input bit kind, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output bit exc);
    int     sa, sb, lo;
    longint prod;
    sa = a;
    sb = b;
    res = '0;
    exc = 1'b0;
    if (kind) begin
      if (sb == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) exc = 1'b1;
      else res = 32'(sa / sb);
    end else begin
      prod = longint'(sa) * longint'(sb);
      lo   = int'(prod[31:0]);
      res  = prod[31:0];
      exc  = (prod != longint'(lo));
    end
  endtask

  // One complete op; d = cycles from the pulse to md_ready (d > TO means the unit never answers).
  task automatic do_op(input bit kind, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int d, input bit stale);
    int          n, p, w;
    logic [31:0] res;
    bit          exc;
    pulse_t      pe;
    wb_t         e;
    unit_model(kind, a, b, res, exc);
    n = cyc;
    p = n + 1;
    w = (d <= TO) ? p + d + 1 : p + TO + 1;
    op_valid = 1'b1; op_is_div = kind; op_a = a; op_b = b; op_rd = rd;
    flush = 1'b0; reset = 1'b0;
    md_ready = stale; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
    pe.cyc = p; pe.kind = kind; pe.a = a; pe.b = b;
    pq.push_back(pe);
    e.cyc = w;
    if (d > TO) begin
      e.rd = RSTATUS; e.data = kind ? DIV_EXC : MULT_EXC; e.to = 1'b1;
    end else if (exc) begin
      e.rd = RSTATUS; e.data = kind ? DIV_EXC : MULT_EXC; e.to = 1'b0;
    end else begin
      e.rd = rd; e.data = res; e.to = 1'b0;
    end
    if (d > TO || exc || rd != 5'd0) wq.push_back(e);
    for (int c = n; c < w; c++) exp_stall[c] = 1'b1;
    for (int c = p; c <= w; c++) exp_busy[c] = 1'b1;
    for (int c = p; c <= w; c++) begin
      @(posedge clk); #1;
      md_ready     = (c == p && stale) || (c == p + d);
      md_result    = (c == p + d) ? res : $urandom;
      md_exception = (c == p + d) ? exc : 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    op_valid = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  // Op killed by flush k cycles after its pulse slot (k = 0 flushes START itself).
  task automatic do_flush_op(input bit kind, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int k);
    int     n, p, f;
    pulse_t pe;
    n = cyc;
    p = n + 1;
    f = p + k;
    op_valid = 1'b1; op_is_div = kind; op_a = a; op_b = b; op_rd = rd;
    flush = 1'b0; reset = 1'b0; md_ready = 1'b0;
    if (k > 0) begin
      pe.cyc = p; pe.kind = kind; pe.a = a; pe.b = b;
      pq.push_back(pe);
    end
    for (int c = n; c < f; c++) exp_stall[c] = 1'b1;
    for (int c = p; c < f; c++) exp_busy[c] = 1'b1;
    dc_busy[f] = 1'b1;
    for (int c = p; c <= f + 2; c++) begin
      @(posedge clk); #1;
      md_result = $urandom;
      if (c == f) begin
        flush = 1'b1; op_valid = 1'b0; md_ready = 1'($urandom_range(0, 1));
      end else if (c == f + 2) begin
        flush = 1'b0; md_ready = 1'b1;
      end else begin
        flush = 1'b0; md_ready = 1'b0;
      end
    end
    @(posedge clk); #1;
    md_ready = 1'b0;
  endtask

  // Op abandoned by a one-cycle reset k cycles after its pulse.
  task automatic do_reset_op(input bit kind, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int k);
    int     n, p, r;
    pulse_t pe;
    n = cyc;
    p = n + 1;
    r = p + k;
    op_valid = 1'b1; op_is_div = kind; op_a = a; op_b = b; op_rd = rd;
    flush = 1'b0; reset = 1'b0; md_ready = 1'b0;
    pe.cyc = p; pe.kind = kind; pe.a = a; pe.b = b;
    pq.push_back(pe);
    for (int c = n; c < r; c++) exp_stall[c] = 1'b1;
    for (int c = p; c < r; c++) exp_busy[c] = 1'b1;
    exp_quiet[r] = 1'b1;
    exp_quiet[r + 1] = 1'b1;
    for (int c = p; c <= r + 1; c++) begin
      @(posedge clk); #1;
      if (c == r) begin
        reset = 1'b1; op_valid = 1'b0; md_ready = 1'($urandom_range(0, 1));
      end else begin
        reset = 1'b0; md_ready = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    pulse_t pe;
    wb_t    we;
    if (exp_quiet.exists(cyc))
      check("quiet_outputs", 64'(|{md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b, stall,
                                   busy, wb_valid, wb_rd, wb_data, timeout}), 64'd0);
    check("stall", 64'(stall), 64'(exp_stall.exists(cyc)));
    if (!dc_busy.exists(cyc)) check("busy", 64'(busy), 64'(exp_busy.exists(cyc)));
    check("timeout_only_with_wb", 64'(timeout & ~wb_valid), 64'd0);
    if (md_ctrl_mult || md_ctrl_div) begin
      check("pulse_expected", 64'(pq.size() > 0), 64'd1);
      if (pq.size() > 0) begin
        pe = pq.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(pe.cyc));
        check("pulse_kind", 64'({md_ctrl_mult, md_ctrl_div}), pe.kind ? 64'd1 : 64'd2);
        check("operand_a", 64'(md_operand_a), 64'(pe.a));
        check("operand_b", 64'(md_operand_b), 64'(pe.b));
      end
    end
    if (wb_valid) begin
      check("wb_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        we = wq.pop_front();
        check("wb_cycle", 64'(cyc), 64'(we.cyc));
        check("wb_rd", 64'(wb_rd), 64'(we.rd));
        check("wb_data", 64'(wb_data), 64'(we.data));
        check("wb_timeout", 64'(timeout), 64'(we.to));
      end
    end
  end

  initial begin
    bit          kind;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          sel;
    reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0; op_rd = '0;
    flush = 1'b0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    for (int c = 0; c <= 4; c++) exp_quiet[c] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 1'b0);   // 7 * -3 -> 0xFFFFFFEB
    do_op(1'b1, 32'd10, 32'd0, 5'd9, 12, 1'b0);          // div by zero -> rstatus 5
    do_op(1'b0, 32'd3, 32'd4, 5'd7, NEVER, 1'b0);        // timeout -> rstatus 4
    do_op(1'b1, 32'd100, 32'd7, 5'd3, TO, 1'b0);         // ready on the terminal cycle wins
    do_op(1'b0, 32'd6, 32'd6, 5'd2, 1, 1'b1);            // stale ready through START
    do_op(1'b1, 32'hFFFF_FF9C, 32'd9, 5'd4, 3, 1'b1);
    do_flush_op(1'b0, 32'd11, 32'd12, 5'd6, 9);
    do_op(1'b1, 32'd81, 32'd9, 5'd8, 5, 1'b0);           // accepted right after the flush
    do_flush_op(1'b1, 32'd1, 32'd2, 5'd6, 0);
    do_reset_op(1'b1, 32'd50, 32'd5, 5'd10, 5);
    do_op(1'b0, 32'd2, 32'd3, 5'd0, 4, 1'b0);            // $r0 write suppressed
    do_op(1'b0, 32'h4000_0000, 32'd4, 5'd0, 6, 1'b0);    // overflow still writes rstatus
    do_op(1'b0, 32'd5, 32'd5, 5'd12, 2, 1'b0);           // back-to-back pair
    do_op(1'b1, 32'd99, 32'd10, 5'd13, 2, 1'b0);
    op_valid = 1'b1; flush = 1'b1; op_a = 32'd1; op_b = 32'd1; op_rd = 5'd1;  // flushed offer
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      sel  = $urandom_range(0, 9);
      kind = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200) - 100);
      b    = ($urandom_range(0, 4) == 0) ? 32'd0 :
             ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200) - 100);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (sel == 0)      do_flush_op(kind, a, b, rd, $urandom_range(0, 10));
      else if (sel == 1) do_reset_op(kind, a, b, rd, $urandom_range(1, 10));
      else               do_op(kind, a, b, rd, $urandom_range(1, 45), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    repeat (5) begin @(posedge clk); #1; end
    check("pulse_queue_drained", 64'(pq.size()), 64'd0);
    check("wb_queue_drained", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Issue/completion controller between the processor execute stage and the iterative multdiv unit.
- Accepts a mult or div from X and launches it with a one-cycle ctrl pulse on held operands.
- Stalls the pipeline until the unit reports ready, then emits a single write-back beat.
- A unit exception is converted into an rstatus write, using the team's $r30 convention.

Parameters:
- RSTATUS_REG, 5'd30, destination register for exception codes
- MULT_EXC_CODE, 32'd4, rstatus value on mult exception
- DIV_EXC_CODE, 32'd5, rstatus value on div exception
- TIMEOUT_CYCLES, 40, BUSY cycles without ready before a forced exception

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  X stage holds a mult/div instruction
- op_is_div  in  1  1 = div, 0 = mult
- op_a  in  32  operand A
- op_b  in  32  operand B
- op_rd  in  5  destination register
- flush  in  1  kill any in-flight operation
- md_result  in  32  data_result from the unit
- md_exception  in  1  data_exception from the unit
- md_ready  in  1  data_resultRDY from the unit
- md_ctrl_mult  out  1  one-cycle start pulse, mult
- md_ctrl_div  out  1  one-cycle start pulse, div
- md_operand_a  out  32  held operand A
- md_operand_b  out  32  held operand B
- stall  out  1  freeze F/D/X
- busy  out  1  operation in flight
- wb_valid  out  1  one-cycle write-back strobe
- wb_rd  out  5  write-back register
- wb_data  out  32  write-back data
- timeout  out  1  set with wb_valid when the beat came from timeout

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and clears operand, rd, kind and counter registers. All outputs are 0 during and after reset.
- Reset mid-operation abandons the operation; no wb is produced.
- States: IDLE, START, BUSY, DONE.
- IDLE
  - stall = op_valid (combinational).
  - On op_valid: latch op_a, op_b, op_rd, op_is_div; go to START.
- START (exactly 1 cycle)
  - md_ctrl_div = kind, md_ctrl_mult = ~kind, both driven from registered kind; md_operand_a/b come from the latched registers.
  - md_ready is ignored (it may be stale from the previous operation).
  - Clear the timeout counter; go to BUSY.
- BUSY
  - Counter increments each cycle.
  - md_ready = 1: capture md_result and md_exception; go to DONE.
  - Otherwise, counter == TIMEOUT_CYCLES-1: set the timeout capture; go to DONE.
  - md_ready and timeout in the same cycle: ready wins.
- DONE (exactly 1 cycle)
  - wb_valid = 1.
  - No exception: wb_rd = latched rd, wb_data = captured result.
  - Exception or timeout: wb_rd = RSTATUS_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE by kind.
  - wb_rd = 0 with no exception: wb_valid = 0 (writes to $r0 are suppressed).
  - op_valid is ignored (the same instruction is still in X); go to IDLE.
- stall = (IDLE & op_valid) | START | BUSY. stall is 0 in DONE, so the instruction leaves X in the same cycle as the wb beat.
- busy = START | BUSY | DONE.
- md_operand_a/b hold their latched value from acceptance until the next acceptance.
- Latency: accept in cycle N, pulse in N+1, BUSY from N+2. With md_ready in cycle R, wb_valid is in R+1.
- flush, any state → IDLE next cycle:
  - Same-cycle outputs are suppressed: no ctrl pulse, wb_valid = 0, stall = 0.
  - flush beats md_ready and timeout.
  - flush in IDLE with op_valid: the op is not accepted.
- Back-to-back ops: the earliest next acceptance is the cycle after DONE.
- Arithmetic: the counter is 6 bits, saturating; no other arithmetic.

Decomposition:
- Package md_ctrl_pkg holds:
  - state encoding (IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3);
  - RSTATUS_REG default;
  - exception code constants.
- Sub-module md_timeout_counter: 6-bit, synchronous clear and enable, terminal-count output compared against TIMEOUT_CYCLES.

Test Plan:
- Mult, no exception: op_valid with a=7, b=-3, rd=5; model md_ready 33 cycles after the pulse with md_result=-21 → one md_ctrl_mult pulse with operands 7/-3; stall high until DONE; wb_valid one cycle with rd=5, data=0xFFFFFFEB.
- Div exception: div with a=10, b=0; model md_ready with md_exception=1 → md_ctrl_div pulse; wb rd=30, data=5; timeout=0.
- Timeout: mult issued, md_ready never asserted → wb_valid exactly TIMEOUT_CYCLES+1 cycles after the pulse; rd=30, data=4, timeout=1.
- Stale ready: md_ready held high through START → ready is ignored in START; wb occurs only after ready is re-sampled in BUSY, i.e. no wb earlier than pulse+2.
- Flush in BUSY at cycle 10, then md_ready at cycle 12 → state IDLE at cycle 11, no wb_valid, stall=0 from cycle 10. A new op at cycle 13 pulses at cycle 14.
- Reset mid-BUSY, then rd=0 mult with no exception → all outputs 0 after reset. The later op completes with wb_valid=0 but stall released normally.
